// File: rtl/lane_arb_pkg.sv
// Shared constants, FSM state type and lane-slice helper for the lane round-robin arbiter.
package lane_arb_pkg;

    localparam int unsigned N_LANE = 4;
    localparam int unsigned LANE_W = 2;
    localparam int unsigned SEL_W  = 2;
    localparam int unsigned DATA_W = N_LANE * LANE_W;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } arb_state_e;

    // Returns lane idx of the packed bus, bit-reversed to match the lane-select datapath.
    function automatic logic [LANE_W-1:0] lane_swap(input logic [DATA_W-1:0] data,
                                                    input logic [SEL_W-1:0]  idx);
        logic [LANE_W-1:0] slice;
        logic [LANE_W-1:0] res;
        slice = '0;
        res   = '0;
        for (int unsigned i = 0; i < N_LANE; i++) begin
            if (idx == SEL_W'(i)) begin
                slice = data[LANE_W*i +: LANE_W];
            end
        end
        for (int unsigned k = 0; k < LANE_W; k++) begin
            res[LANE_W-1-k] = slice[k];
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set candidate searching upward from ptr+1 with wrap.
module rr_pick
    import lane_arb_pkg::*;
(
    input  logic [N_LANE-1:0] cand_i,
    input  logic [SEL_W-1:0]  ptr_i,
    output logic              any_hit_o,
    output logic [SEL_W-1:0]  win_idx_o
);

    logic [N_LANE-1:0] rot;
    logic [SEL_W-1:0]  base;
    logic [SEL_W-1:0]  off;
    logic              hit;

    // Rotate so that lane ptr+1 sits at position 0, find first, then map back.
    always_comb begin
        rot  = '0;
        off  = '0;
        hit  = 1'b0;
        base = ptr_i + SEL_W'(1);
        for (int unsigned j = 0; j < N_LANE; j++) begin
            rot[j] = cand_i[SEL_W'(base + SEL_W'(j))];
        end
        for (int unsigned j = 0; j < N_LANE; j++) begin
            if (!hit && rot[j]) begin
                hit = 1'b1;
                off = SEL_W'(j);
            end
        end
        any_hit_o = hit;
        win_idx_o = base + off;
    end

endmodule

// File: rtl/lane_rr_arbiter.sv
// Round-robin arbiter sharing one registered lane channel among four requesters.
module lane_rr_arbiter
    import lane_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_LANE-1:0] req,
    input  logic [DATA_W-1:0] data_in,
    output logic [N_LANE-1:0] ack,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LANE_W-1:0] out_data,
    output logic [SEL_W-1:0]  out_sel,
    output logic              busy
);

    arb_state_e        state_q, state_d;
    logic [SEL_W-1:0]  ptr_q, ptr_d;
    logic              out_valid_q, out_valid_d;
    logic [LANE_W-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0]  out_sel_q, out_sel_d;

    logic              hs_c;
    logic [N_LANE-1:0] sel_onehot_c;
    logic [N_LANE-1:0] pick_cand_c;
    logic [SEL_W-1:0]  pick_ptr_c;
    logic              any_hit_c;
    logic [SEL_W-1:0]  win_idx_c;

    assign hs_c         = out_valid_q & out_ready;
    assign sel_onehot_c = N_LANE'(1) << out_sel_q;

    // Candidate set: all requests in IDLE; on a handshake the just-served lane is masked
    // and priority already moves past it.
    always_comb begin
        pick_cand_c = '0;
        pick_ptr_c  = ptr_q;
        case (state_q)
            IDLE: pick_cand_c = req;
            SEND: begin
                if (hs_c) begin
                    pick_cand_c = req & ~sel_onehot_c;
                    pick_ptr_c  = out_sel_q;
                end
            end
            default: ;
        endcase
    end

    rr_pick u_rr_pick (
        .cand_i    (pick_cand_c),
        .ptr_i     (pick_ptr_c),
        .any_hit_o (any_hit_c),
        .win_idx_o (win_idx_c)
    );

    // Next-state and output-register logic.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        case (state_q)
            IDLE: begin
                if (any_hit_c) begin
                    state_d     = SEND;
                    out_valid_d = 1'b1;
                    out_sel_d   = win_idx_c;
                    out_data_d  = lane_swap(data_in, win_idx_c);
                end else begin
                    out_valid_d = 1'b0;
                    out_sel_d   = '0;
                    out_data_d  = '0;
                end
            end
            SEND: begin
                if (hs_c) begin
                    ptr_d = out_sel_q;
                    if (any_hit_c) begin
                        out_valid_d = 1'b1;
                        out_sel_d   = win_idx_c;
                        out_data_d  = lane_swap(data_in, win_idx_c);
                    end else begin
                        state_d     = IDLE;
                        out_valid_d = 1'b0;
                        out_sel_d   = '0;
                        out_data_d  = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, priority pointer and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= SEL_W'(N_LANE - 1);
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
        end
    end

    assign ack       = hs_c ? sel_onehot_c : '0;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign busy      = (state_q == SEND);

endmodule

// File: tb/tb_lane_rr_arbiter.sv
// Directed self-checking bench for lane_rr_arbiter.
module tb_lane_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [7:0] data_in;
    logic [3:0] ack;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_data;
    logic [1:0] out_sel;
    logic       busy;

    int n_chk  = 0;
    int n_fail = 0;

    lane_rr_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .data_in   (data_in),
        .ack       (ack),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req       = 4'b0000;
        out_ready = 1'b0;
        data_in   = 8'h00;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        int         exp_sel [5];
        logic [1:0] exp_dat [4];
        exp_sel = '{0, 1, 2, 3, 0};
        // data 8'hE4: lanes 00,01,10,11 -> swapped 00,10,01,11
        exp_dat = '{2'b00, 2'b10, 2'b01, 2'b11};

        // Reset state
        do_reset();
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_busy",  32'(busy),      32'd0);
        check_eq("rst_ack",   32'(ack),       32'd0);
        check_eq("rst_sel",   32'(out_sel),   32'd0);
        check_eq("rst_data",  32'(out_data),  32'd0);

        // All four requesting with a ready consumer: rotation 0,1,2,3,0
        req = 4'b1111; out_ready = 1'b1; data_in = 8'hE4;
        #1;
        check_eq("rr_idle_valid", 32'(out_valid), 32'd0);
        tick();
        for (int i = 0; i < 5; i++) begin
            check_eq("rr_valid", 32'(out_valid), 32'd1);
            check_eq("rr_sel",   32'(out_sel),   32'(exp_sel[i]));
            check_eq("rr_data",  32'(out_data),  32'(exp_dat[exp_sel[i]]));
            check_eq("rr_ack",   32'(ack),       32'(4'b0001 << exp_sel[i]));
            if (i == 4) req = 4'b0000;
            tick();
        end
        check_eq("rr_end_valid", 32'(out_valid), 32'd0);
        check_eq("rr_end_busy",  32'(busy),      32'd0);

        // Single lane 2 held by back-pressure; data_in changes must not leak through
        do_reset();
        data_in = 8'b10_01_11_00; req = 4'b0100; out_ready = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            check_eq("hold_valid", 32'(out_valid), 32'd1);
            check_eq("hold_sel",   32'(out_sel),   32'd2);
            check_eq("hold_data",  32'(out_data),  32'b10);
            check_eq("hold_ack",   32'(ack),       32'd0);
            check_eq("hold_busy",  32'(busy),      32'd1);
            data_in = (i == 0) ? 8'hFF : 8'h00;
            tick();
        end
        out_ready = 1'b1; req = 4'b0000;
        #1;
        check_eq("hold_hs_ack",  32'(ack),      32'b0100);
        check_eq("hold_hs_data", 32'(out_data), 32'b10);
        tick();
        check_eq("hold_after_valid", 32'(out_valid), 32'd0);
        check_eq("hold_after_ack",   32'(ack),       32'd0);

        // Lone streaming requester gets every other cycle
        do_reset();
        data_in = 8'h00; req = 4'b0010; out_ready = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            check_eq("solo_valid", 32'(out_valid), (i % 2 == 0) ? 32'd1 : 32'd0);
            check_eq("solo_ack",   32'(ack),       (i % 2 == 0) ? 32'b0010 : 32'd0);
            tick();
        end
        req = 4'b0000;
        tick();
        tick();

        // Wrap-around fairness between lanes 3 and 0
        do_reset();
        req = 4'b1000; out_ready = 1'b1;
        tick();
        check_eq("wrap_sel3",  32'(out_sel), 32'd3);
        check_eq("wrap_ack3",  32'(ack),     32'b1000);
        req = 4'b1001;
        tick();
        check_eq("wrap_sel0",  32'(out_sel), 32'd0);
        check_eq("wrap_ack0",  32'(ack),     32'b0001);
        tick();
        check_eq("wrap_sel3b", 32'(out_sel), 32'd3);
        tick();
        check_eq("wrap_sel0b", 32'(out_sel), 32'd0);
        req = 4'b0000;
        tick();
        check_eq("wrap_idle",  32'(out_valid), 32'd0);

        // Async reset mid-SEND drops the beat and restores the pointer
        do_reset();
        req = 4'b0001; out_ready = 1'b1;
        tick();
        check_eq("ar_first_ack", 32'(ack), 32'b0001);
        req = 4'b0000;
        tick();
        req = 4'b0011; out_ready = 1'b0;
        tick();
        check_eq("ar_sel1", 32'(out_sel), 32'd1);
        check_eq("ar_busy", 32'(busy),    32'd1);
        out_ready = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("ar_valid", 32'(out_valid), 32'd0);
        check_eq("ar_busyr", 32'(busy),      32'd0);
        check_eq("ar_ack",   32'(ack),       32'd0);
        tick();
        check_eq("ar_ack_hold", 32'(ack), 32'd0);
        rst_n = 1'b1;
        #1;
        tick();
        check_eq("ar_retry_sel",   32'(out_sel),   32'd0);
        check_eq("ar_retry_valid", 32'(out_valid), 32'd1);
        check_eq("ar_retry_ack",   32'(ack),       32'b0001);
        tick();
        check_eq("ar_next_sel", 32'(out_sel), 32'd1);
        req = 4'b0000;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/lane_rr_arbiter.md
# lane_rr_arbiter

Round-robin arbiter that shares a single 2-bit output channel between four requesters, each presenting one 2-bit lane of an 8-bit packed data bus. It sits in front of the keyed 4:1 lane-select datapath: it decides which lane drives the channel, registers that lane's data, and holds it under a valid/ready handshake until the consumer accepts it. It then acknowledges the winning requester and moves priority past it.

## Interface
- N_LANE, 4, number of requesters/lanes; power of two, at least 2.
- LANE_W, 2, data bits per lane.
- SEL_W, 2, log2(N_LANE).

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- req  in  N_LANE  req[i] high means lane i has a beat pending.
- data_in  in  N_LANE*LANE_W  packed lane data; lane i occupies bits [LANE_W*i+LANE_W-1 : LANE_W*i].
- ack  out  N_LANE  one-cycle pulse on ack[i] when lane i's beat is accepted.
- out_valid  out  1  output beat valid.
- out_ready  in  1  consumer accepts the beat.
- out_data  out  LANE_W  registered data of the granted lane.
- out_sel  out  SEL_W  index of the granted lane.
- busy  out  1  high while in state SEND.

## Operation
- Lane data mapping, fixed: for lane i, out_data[1] = data_in[2i] and out_data[0] = data_in[2i+1]. The lane is bit-swapped, which matches the existing lane-select datapath.
- FSM states: IDLE and SEND.
  - IDLE, any req set: pick the winner. Register out_sel, out_data, out_valid=1 and go to SEND.
  - IDLE, no req: stay in IDLE with outputs held at 0.
- Winner: the first set bit of the candidate vector, searching upward from (ptr+1) mod N_LANE with wrap-around.
- SEND: out_valid, out_sel and out_data stay stable until out_valid && out_ready. On that handshake cycle:
  - ack[out_sel] = 1 (combinational, that cycle only) and ptr <= out_sel.
  - Re-arbitrate the same cycle using candidates = req & ~onehot(out_sel).
  - If candidates are non-zero, load the new winner and stay in SEND (back-to-back beats).
  - Otherwise clear out_valid and return to IDLE.
- Requester protocol: req[i] and its lane data stay stable from assertion until ack[i]. A requester may keep req[i] high after ack[i] to present the next beat. Because of the masking above, that beat is considered no earlier than the cycle after ack.
- Dropping req[i] in SEND before ack is a protocol violation. The grant is held anyway and the registered data is still delivered.
- Data is captured at arbitration time. Later changes on data_in do not affect a beat already in SEND.

## Timing
- Reset (async assert, sync-safe release): state=IDLE, ptr=N_LANE-1 (lane 0 has first priority), out_valid=0, out_data=0, out_sel=0, busy=0, ack=0.
- Latency: req rising in IDLE at cycle t gives out_valid=1 at t+1.
- A consumer holding out_ready high gets the first beat at t+1, ack at t+1, and the next lane's beat at t+2.
- A single requester streaming alone gets at most one beat every 2 cycles (the ack cycle is masked). Two or more active requesters get one beat per cycle.
- out_ready while out_valid=0 is ignored.
- If rst_n asserts mid-SEND, the beat is dropped with no ack and the requester retries after reset.
- ack is never high when out_valid is low. At most one ack bit is high per cycle.

## Structure
- Package lane_arb_pkg holds:
  - the state enum (IDLE, SEND);
  - N_LANE, LANE_W and SEL_W default constants;
  - a function that returns the bit-swapped lane slice.
- One sub-module, rr_pick: combinational priority picker. Inputs are the candidate vector and ptr; outputs are any_hit and win_idx, using rotate, find-first, unrotate.
- The top level contains the FSM, the output registers and ptr.

## Test plan
- After reset: req=4'b1111 at cycle 1 with out_ready=1 -> out_sel sequence 0,1,2,3,0 on cycles 2-6, with ack[out_sel] high on each of those cycles.
- data_in=8'b10_01_11_00, req=4'b0100 -> out_sel=2, out_data=2'b10 (bit-swapped 2'b01), held for 3 cycles while out_ready=0, then ack=4'b0100 when out_ready rises.
- Only req[1] high continuously, out_ready=1 -> out_valid pattern 1,0,1,0. ack[1] pulses every other cycle.
- req=4'b1001 with ptr=3 after serving lane 3 -> lane 0 wins. Then lane 3 wins, and lane 0 does not win twice in a row.
- Change data_in while in SEND with out_ready=0 -> out_data does not change until the handshake.
- Assert rst_n=0 asynchronously mid-SEND -> out_valid, busy and ack are 0 within the same cycle, ptr=3, and no ack is issued for the dropped beat.
